// File: rtl/irq_controller_pkg.sv
// Shared definitions for the external interrupt controller: register map,
// FSM encoding, ID width and the fixed-priority helper.
package irq_controller_pkg;

  // Interrupt IDs are 5 bits wide; ID 0 means "no interrupt".
  localparam int unsigned IdWidth = 5;

  // Word index of each register (byte offset [4:2]).
  localparam logic [2:0] RegPending = 3'd0;  // 0x00
  localparam logic [2:0] RegEnable  = 3'd1;  // 0x04
  localparam logic [2:0] RegTrigger = 3'd2;  // 0x08
  localparam logic [2:0] RegClaim   = 3'd3;  // 0x0C
  localparam logic [2:0] RegStatus  = 3'd4;  // 0x10

  typedef enum logic {
    StIdle    = 1'b0,
    StService = 1'b1
  } irq_state_e;

  // Lowest set bit index in [31:1]; bit 0 is never an ID, so 0 means none.
  function automatic logic [IdWidth-1:0] lowest_id(input logic [31:0] vec);
    logic [IdWidth-1:0] id;
    id = '0;
    for (int i = 31; i >= 1; i--) begin
      if (vec[i]) id = IdWidth'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/irq_controller_gateway.sv
// Per-source gateway: synchroniser, edge detector, edge/level gating and the
// pending flop for a single interrupt source.
module irq_controller_gateway #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_irq,        // asynchronous device line
  input  logic i_edge_mode,  // 1 = rising edge, 0 = active-high level
  input  logic i_blocked,    // this source is the ID currently in service
  input  logic i_claim,      // this source is being claimed this cycle
  input  logic i_trig_chg,   // trigger mode of this source is being changed
  output logic o_pending
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_pending;
  logic                   w_s;
  logic                   w_edge;
  logic                   w_pending_d;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_edge = w_s & ~r_prev;

  // Next pending value: mode change wipes it, an edge beats a same-cycle claim,
  // level mode simply follows the synchronised line unless in service.
  always_comb begin
    w_pending_d = r_pending;
    if (i_trig_chg) begin
      w_pending_d = 1'b0;
    end else if (i_edge_mode) begin
      if (w_edge) begin
        w_pending_d = 1'b1;
      end else if (i_claim) begin
        w_pending_d = 1'b0;
      end
    end else begin
      w_pending_d = w_s & ~i_blocked & ~i_claim;
    end
  end

  // Synchroniser chain, previous-level flop and pending flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync    <= '0;
      r_prev    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_irq};
      r_prev    <= w_s;
      r_pending <= w_pending_d;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped external interrupt controller: per-source gateways, enable
// and trigger registers, fixed-priority arbiter, claim/complete FSM and bus.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int unsigned N_SRC       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_SRC-1:0]     i_irq_src,
  input  logic [4:0]           i_bus_addr,
  input  logic [31:0]          i_bus_wdata,
  input  logic                 i_bus_we,
  input  logic                 i_bus_re,
  output logic [31:0]          o_bus_rdata,
  output logic                 o_interrupt,
  output logic [IdWidth-1:0]   o_claim_id
);

  // Architectural state.
  logic [N_SRC:1]        r_enable;
  logic [N_SRC:1]        r_trigger;
  irq_state_e            r_state;
  logic [IdWidth-1:0]    r_claim_id;
  logic [31:0]           r_rdata;
  logic                  r_interrupt;

  // Combinational signals.
  logic [N_SRC:1]        w_pending;
  logic [31:0]           w_pend_vec;
  logic [31:0]           w_en_vec;
  logic [31:0]           w_trig_vec;
  logic [IdWidth-1:0]    w_best;
  logic                  w_wr;
  logic                  w_rd;
  logic [2:0]            w_reg;
  logic                  w_claim_go;
  logic                  w_complete;
  logic                  w_trig_wr;
  irq_state_e            w_state_d;
  logic [IdWidth-1:0]    w_claim_id_d;
  logic [31:0]           w_rdata_d;

  // Write strobe wins over a simultaneous read strobe.
  assign w_wr  = i_bus_we;
  assign w_rd  = i_bus_re & ~i_bus_we;
  assign w_reg = i_bus_addr[4:2];

  assign w_trig_wr = w_wr && (w_reg == RegTrigger);

  // Gateways: one per source, bit g of the vectors is source ID g.
  for (genvar g = 1; g <= N_SRC; g++) begin : g_src
    localparam logic [IdWidth-1:0] Id = IdWidth'(g);
    logic w_blocked;
    logic w_claim;
    logic w_trig_chg;

    assign w_blocked  = (r_state == StService) && (r_claim_id == Id);
    assign w_claim    = w_claim_go && (w_best == Id);
    assign w_trig_chg = w_trig_wr && (i_bus_wdata[g] != r_trigger[g]);

    irq_controller_gateway #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_gateway (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_irq       (i_irq_src[g-1]),
      .i_edge_mode (r_trigger[g]),
      .i_blocked   (w_blocked),
      .i_claim     (w_claim),
      .i_trig_chg  (w_trig_chg),
      .o_pending   (w_pending[g])
    );
  end

  // Widen the per-source vectors to the 32-bit register layout.
  always_comb begin
    w_pend_vec          = '0;
    w_en_vec            = '0;
    w_trig_vec          = '0;
    w_pend_vec[N_SRC:1] = w_pending;
    w_en_vec[N_SRC:1]   = r_enable;
    w_trig_vec[N_SRC:1] = r_trigger;
  end

  // Fixed priority: lowest enabled pending ID wins.
  assign w_best = lowest_id(w_pend_vec & w_en_vec);

  // Claim/complete FSM next state.
  always_comb begin
    w_state_d    = r_state;
    w_claim_id_d = r_claim_id;
    w_claim_go   = 1'b0;
    w_complete   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_rd && (w_reg == RegClaim) && (w_best != '0)) begin
          w_claim_go   = 1'b1;
          w_state_d    = StService;
          w_claim_id_d = w_best;
        end
      end
      StService: begin
        if (w_wr && (w_reg == RegClaim) && (i_bus_wdata[IdWidth-1:0] == r_claim_id)) begin
          w_complete   = 1'b1;
          w_state_d    = StIdle;
          w_claim_id_d = '0;
        end
      end
      default: begin
        w_state_d    = StIdle;
        w_claim_id_d = '0;
      end
    endcase
  end

  // Read mux; data holds until the next read strobe.
  always_comb begin
    w_rdata_d = r_rdata;
    if (w_rd) begin
      case (w_reg)
        RegPending: w_rdata_d = w_pend_vec;
        RegEnable:  w_rdata_d = w_en_vec;
        RegTrigger: w_rdata_d = w_trig_vec;
        RegClaim:   w_rdata_d = (r_state == StIdle) ? {{(32 - IdWidth){1'b0}}, w_best} : '0;
        RegStatus:  w_rdata_d = {26'b0, (r_state == StService), r_claim_id};
        default:    w_rdata_d = '0;
      endcase
    end
  end

  // Register file, FSM state, read data and interrupt request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_enable    <= '0;
      r_trigger   <= '0;
      r_state     <= StIdle;
      r_claim_id  <= '0;
      r_rdata     <= '0;
      r_interrupt <= 1'b0;
    end else begin
      if (w_wr && (w_reg == RegEnable)) r_enable <= i_bus_wdata[N_SRC:1];
      if (w_trig_wr) r_trigger <= i_bus_wdata[N_SRC:1];
      r_state     <= w_state_d;
      r_claim_id  <= w_claim_id_d;
      r_rdata     <= w_rdata_d;
      r_interrupt <= (r_state == StIdle) && (w_best != '0);
    end
  end

  assign o_bus_rdata = r_rdata;
  assign o_interrupt = r_interrupt;
  assign o_claim_id  = r_claim_id;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: bus reads are scoreboarded, control
// outputs are checked directly at cycle-accurate points.
module tb_irq_controller;

  localparam logic [4:0] AddrPending = 5'h00;
  localparam logic [4:0] AddrEnable  = 5'h04;
  localparam logic [4:0] AddrTrigger = 5'h08;
  localparam logic [4:0] AddrClaim   = 5'h0C;
  localparam logic [4:0] AddrStatus  = 5'h10;

  logic        clk;
  logic        rst;
  logic [7:0]  irq_src;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_rdata;
  logic        interrupt;
  logic [4:0]  claim_id;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       n_checks;
  int       n_errors;
  logic     rd_vld;

  irq_controller #(
    .N_SRC       (8),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_irq_src   (irq_src),
    .i_bus_addr  (bus_addr),
    .i_bus_wdata (bus_wdata),
    .i_bus_we    (bus_we),
    .i_bus_re    (bus_re),
    .o_bus_rdata (bus_rdata),
    .o_interrupt (interrupt),
    .o_claim_id  (claim_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Read data is valid one cycle after the read strobe.
  always @(posedge clk) rd_vld <= bus_re & ~bus_we & ~rst;

  always @(negedge clk) begin
    if (rd_vld) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_read", 32'd1, 32'd0);
      end else begin
        sb_item_t it;
        it = sb_q.pop_front();
        check(it.tag, bus_rdata, it.exp);
      end
    end
  end

  task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_we    = 1'b1;
    bus_addr  = addr;
    bus_wdata = data;
    @(negedge clk);
    bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] addr, input string tag, input logic [31:0] exp);
    sb_item_t it;
    @(negedge clk);
    bus_re   = 1'b1;
    bus_addr = addr;
    it.tag   = tag;
    it.exp   = exp;
    sb_q.push_back(it);
    @(negedge clk);
    bus_re   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    irq_src = '0;
    @(negedge clk);
    rst     = 1'b0;
  endtask

  task automatic wait_int(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (interrupt) break;
      @(negedge clk);
    end
    check(tag, {31'b0, interrupt}, 32'd1);
  endtask

  task automatic pulse(input logic [7:0] bits);
    @(negedge clk);
    irq_src = bits;
    @(negedge clk);
    irq_src = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    irq_src   = '0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    bus_re    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst_interrupt", {31'b0, interrupt}, 32'd0);
    check("rst_claim_id", {27'b0, claim_id}, 32'd0);
    check("rst_rdata", bus_rdata, 32'd0);

    // 1: level source ID2, latency and claim.
    bus_write(AddrEnable, 32'h04);
    bus_write(AddrTrigger, 32'h00);
    irq_src = 8'h02;
    repeat (3) @(negedge clk);
    check("t1_int_early", {31'b0, interrupt}, 32'd0);
    @(negedge clk);
    check("t1_int_latency", {31'b0, interrupt}, 32'd1);
    bus_read(AddrClaim, "t1_claim", 32'd2);
    @(negedge clk);
    check("t1_int_drop", {31'b0, interrupt}, 32'd0);
    check("t1_claim_id", {27'b0, claim_id}, 32'd2);

    // 2: status, mismatched complete, real complete, level re-asserts.
    bus_read(AddrStatus, "t2_status", 32'h22);
    bus_write(AddrClaim, 32'd5);
    check("t2_bad_complete", {27'b0, claim_id}, 32'd2);
    bus_read(AddrStatus, "t2_status_after_bad", 32'h22);
    bus_write(AddrClaim, 32'd2);
    check("t2_complete", {27'b0, claim_id}, 32'd0);
    wait_int("t2_reassert", 6);
    irq_src = '0;
    repeat (4) @(negedge clk);
    check("t2_level_gone", {31'b0, interrupt}, 32'd0);

    // 3: edge IDs 1 and 3 pulsed together.
    do_reset();
    bus_write(AddrEnable, 32'h0A);
    bus_write(AddrTrigger, 32'h0A);
    pulse(8'h05);
    repeat (5) @(negedge clk);
    bus_read(AddrPending, "t3_pending", 32'h0A);
    check("t3_int", {31'b0, interrupt}, 32'd1);
    bus_read(AddrClaim, "t3_claim1", 32'd1);
    bus_read(AddrClaim, "t3_claim_nested", 32'd0);
    bus_write(AddrClaim, 32'd1);
    bus_read(AddrClaim, "t3_claim3", 32'd3);
    bus_write(AddrClaim, 32'd3);
    bus_read(AddrPending, "t3_pending_empty", 32'h00);

    // 4: edge ID4 re-pends during its own service.
    bus_write(AddrTrigger, 32'h1A);
    bus_write(AddrEnable, 32'h10);
    pulse(8'h08);
    repeat (5) @(negedge clk);
    bus_read(AddrClaim, "t4_claim4", 32'd4);
    pulse(8'h08);
    repeat (5) @(negedge clk);
    bus_read(AddrPending, "t4_pending", 32'h10);
    check("t4_int_in_service", {31'b0, interrupt}, 32'd0);
    bus_write(AddrClaim, 32'd4);
    check("t4_int_at_complete", {31'b0, interrupt}, 32'd0);
    @(negedge clk);
    check("t4_int_after", {31'b0, interrupt}, 32'd1);
    bus_read(AddrClaim, "t4_claim4_again", 32'd4);
    bus_write(AddrClaim, 32'd4);

    // 5: pending but masked.
    do_reset();
    irq_src = 8'h02;
    repeat (6) @(negedge clk);
    check("t5_int_masked", {31'b0, interrupt}, 32'd0);
    bus_read(AddrClaim, "t5_claim_masked", 32'd0);
    bus_read(AddrPending, "t5_pending", 32'h04);
    bus_write(AddrEnable, 32'h04);
    @(negedge clk);
    check("t5_int_enabled", {31'b0, interrupt}, 32'd1);

    // 6: reset during service with another source pending.
    bus_write(AddrEnable, 32'h24);
    irq_src = 8'h12;
    repeat (6) @(negedge clk);
    bus_read(AddrClaim, "t6_claim2", 32'd2);
    check("t6_claim_id", {27'b0, claim_id}, 32'd2);
    bus_read(AddrPending, "t6_pending", 32'h20);
    do_reset();
    check("t6_rst_claim_id", {27'b0, claim_id}, 32'd0);
    check("t6_rst_int", {31'b0, interrupt}, 32'd0);
    check("t6_rst_rdata", bus_rdata, 32'd0);
    bus_read(AddrPending, "t6_rst_pending", 32'h00);
    bus_read(AddrEnable, "t6_rst_enable", 32'h00);
    bus_read(AddrStatus, "t6_rst_status", 32'h00);
    repeat (2) @(negedge clk);

    check("sb_drain", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
